// File: rtl/game_turn_ctl_pkg.sv
// game_turn_ctl_pkg: shared state/message encodings and grid sizing helpers
package game_turn_ctl_pkg;
    typedef enum logic [2:0] {
        ST_SETUP, ST_WAIT_PEER, ST_CHECK, ST_RESULT_TX,
        ST_AIM, ST_SHOT_TX, ST_WAIT_RESULT, ST_GAME_OVER
    } state_t;
    typedef enum logic [1:0] {
        MSG_NONE = 2'b00, MSG_SHOT = 2'b01, MSG_MISS = 2'b10, MSG_HIT = 2'b11
    } msg_kind_t;
    function automatic int cw_of(input int n);
        return $clog2(n);
    endfunction
    function automatic int aw_of(input int n);
        return 2 * $clog2(n);
    endfunction
endpackage

// File: rtl/grid_cursor_map.sv
// grid_cursor_map: frame-registered pixel to {row,col} cell mapping
module grid_cursor_map import game_turn_ctl_pkg::*; #(
    parameter int GRID_N   = 10,
    parameter int CELL_PX  = 32,
    parameter int ORIGIN_X = 608,
    parameter int ORIGIN_Y = 193,
    localparam int CW = cw_of(GRID_N),
    localparam int AW = aw_of(GRID_N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick_i,
    input  logic [11:0]   xpos_i,
    input  logic [11:0]   ypos_i,
    output logic [AW-1:0] cell_o,
    output logic          in_grid_o
);
    localparam int SH = $clog2(CELL_PX);
    logic [11:0]   col, row;
    logic          in_grid_d, in_grid_q;
    logic [AW-1:0] cell_q;
    // Wrapped offsets left of/above the origin are rejected by the origin compares
    always_comb begin
        col = (xpos_i - 12'(ORIGIN_X)) >> SH;
        row = (ypos_i - 12'(ORIGIN_Y)) >> SH;
        in_grid_d = xpos_i >= 12'(ORIGIN_X) && ypos_i >= 12'(ORIGIN_Y) &&
                    col < 12'(GRID_N) && row < 12'(GRID_N);
    end
    // Cursor is sampled once per frame so it is stable for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_q    <= '0;
            in_grid_q <= 1'b0;
        end else if (frame_tick_i) begin
            cell_q    <= {row[CW-1:0], col[CW-1:0]};
            in_grid_q <= in_grid_d;
        end
    end
    assign cell_o    = cell_q;
    assign in_grid_o = in_grid_q;
endmodule

// File: rtl/game_turn_ctl.sv
// game_turn_ctl: turn sequencing, shot/result exchange and win detection
module game_turn_ctl import game_turn_ctl_pkg::*; #(
    parameter int GRID_N         = 10,
    parameter int CELL_PX        = 32,
    parameter int ORIGIN_X       = 608,
    parameter int ORIGIN_Y       = 193,
    parameter int SHIP_CELLS     = 11,
    parameter int TIMEOUT_FRAMES = 120,
    localparam int AW = aw_of(GRID_N),
    localparam int HW = $clog2(SHIP_CELLS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick_i,
    input  logic          mouse_left_i,
    input  logic [11:0]   mouse_xpos_i,
    input  logic [11:0]   mouse_ypos_i,
    input  logic          first_player_i,
    input  logic [HW-1:0] ship_count_i,
    output logic [AW-1:0] cursor_cell_o,
    output logic          cursor_in_grid_o,
    output logic          pick_ship_o,
    output logic          pick_place_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [1:0]    tx_kind_o,
    output logic [AW-1:0] tx_addr_o,
    input  logic          rx_valid_i,
    input  logic [1:0]    rx_kind_i,
    input  logic [AW-1:0] rx_addr_i,
    output logic          chk_req_o,
    output logic [AW-1:0] chk_addr_o,
    input  logic          chk_hit_i,
    output logic          game_over_o,
    output logic          win_o,
    output logic [6:0]    state_led_o
);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [HW-1:0] SC    = HW'(SHIP_CELLS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_FRAMES - 1);

    state_t        state_d, state_q;
    logic [AW-1:0] peer_d, peer_q, shot_d, shot_q;
    logic          hit_d, hit_q, win_d, win_q, mouse_q, click;
    logic [HW-1:0] opp_d, opp_q, my_d, my_q;
    logic [TW-1:0] tmo_d, tmo_q;
    logic          pick_ship_d, pick_ship_q, pick_place_d, pick_place_q;
    logic          tx_valid_d, tx_valid_q, chk_req_d, chk_req_q, game_over_d, game_over_q;
    logic [1:0]    tx_kind_d, tx_kind_q;
    logic [AW-1:0] tx_addr_d, tx_addr_q, chk_addr_d, chk_addr_q;
    logic [6:0]    led_d, led_q;

    grid_cursor_map #(
        .GRID_N(GRID_N), .CELL_PX(CELL_PX), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y)
    ) u_map (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick_i),
        .xpos_i(mouse_xpos_i), .ypos_i(mouse_ypos_i),
        .cell_o(cursor_cell_o), .in_grid_o(cursor_in_grid_o)
    );

    assign click = mouse_left_i & ~mouse_q;

    // Next-state and bookkeeping; rx that does not fit the current state falls through and is dropped
    always_comb begin
        state_d = state_q;
        peer_d  = peer_q;
        shot_d  = shot_q;
        hit_d   = hit_q;
        opp_d   = opp_q;
        my_d    = my_q;
        tmo_d   = tmo_q;
        win_d   = win_q;
        case (state_q)
            ST_SETUP:
                if (ship_count_i == SC && !mouse_left_i)
                    state_d = first_player_i ? ST_AIM : ST_WAIT_PEER;
            ST_WAIT_PEER:
                if (rx_valid_i && rx_kind_i == MSG_SHOT) begin
                    peer_d  = rx_addr_i;
                    state_d = ST_CHECK;
                end
            ST_CHECK: begin
                hit_d   = chk_hit_i;
                opp_d   = (chk_hit_i && opp_q != SC) ? opp_q + 1'b1 : opp_q;
                state_d = ST_RESULT_TX;
            end
            ST_RESULT_TX:
                if (tx_ready_i)
                    state_d = (opp_q == SC) ? ST_GAME_OVER : ST_AIM;
            ST_AIM:
                if (click && cursor_in_grid_o) begin
                    shot_d  = cursor_cell_o;
                    state_d = ST_SHOT_TX;
                end
            ST_SHOT_TX:
                if (tx_ready_i) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_RESULT;
                end
            ST_WAIT_RESULT:
                if (rx_valid_i && (rx_kind_i == MSG_HIT || rx_kind_i == MSG_MISS)) begin
                    my_d    = (rx_kind_i == MSG_HIT && my_q != SC) ? my_q + 1'b1 : my_q;
                    win_d   = my_d == SC;
                    state_d = (my_d == SC) ? ST_GAME_OVER : ST_WAIT_PEER;
                end else if (frame_tick_i) begin
                    tmo_d   = (tmo_q == TLAST) ? '0 : tmo_q + 1'b1;
                    state_d = (tmo_q == TLAST) ? ST_SHOT_TX : ST_WAIT_RESULT;
                end
            default: ;
        endcase
    end

    // Outputs decoded from the next state so they register in step with it
    always_comb begin
        pick_ship_d  = state_d == ST_SETUP && mouse_left_i;
        pick_place_d = state_d == ST_AIM;
        tx_valid_d   = state_d == ST_SHOT_TX || state_d == ST_RESULT_TX;
        tx_kind_d    = state_d == ST_SHOT_TX ? MSG_SHOT :
                       state_d == ST_RESULT_TX ? (hit_d ? MSG_HIT : MSG_MISS) : MSG_NONE;
        tx_addr_d    = state_d == ST_SHOT_TX ? shot_d : state_d == ST_RESULT_TX ? peer_d : '0;
        chk_req_d    = state_d == ST_CHECK;
        chk_addr_d   = state_d == ST_CHECK ? peer_d : '0;
        game_over_d  = state_d == ST_GAME_OVER;
        led_d        = 7'(8'd1 << state_d);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SETUP;
            peer_q       <= '0;
            shot_q       <= '0;
            hit_q        <= 1'b0;
            opp_q        <= '0;
            my_q         <= '0;
            tmo_q        <= '0;
            win_q        <= 1'b0;
            mouse_q      <= 1'b0;
            pick_ship_q  <= 1'b0;
            pick_place_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_kind_q    <= '0;
            tx_addr_q    <= '0;
            chk_req_q    <= 1'b0;
            chk_addr_q   <= '0;
            game_over_q  <= 1'b0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            peer_q       <= peer_d;
            shot_q       <= shot_d;
            hit_q        <= hit_d;
            opp_q        <= opp_d;
            my_q         <= my_d;
            tmo_q        <= tmo_d;
            win_q        <= win_d;
            mouse_q      <= mouse_left_i;
            pick_ship_q  <= pick_ship_d;
            pick_place_q <= pick_place_d;
            tx_valid_q   <= tx_valid_d;
            tx_kind_q    <= tx_kind_d;
            tx_addr_q    <= tx_addr_d;
            chk_req_q    <= chk_req_d;
            chk_addr_q   <= chk_addr_d;
            game_over_q  <= game_over_d;
            led_q        <= led_d;
        end
    end

    assign pick_ship_o  = pick_ship_q;
    assign pick_place_o = pick_place_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_kind_o    = tx_kind_q;
    assign tx_addr_o    = tx_addr_q;
    assign chk_req_o    = chk_req_q;
    assign chk_addr_o   = chk_addr_q;
    assign game_over_o  = game_over_q;
    assign win_o        = win_q;
    assign state_led_o  = led_q;
endmodule

// File: tb/tb_game_turn_ctl.sv
// tb_game_turn_ctl: directed checks of setup, aiming, exchange, timeout and win
module tb_game_turn_ctl;
    logic        clk = 1'b0, rst_n = 1'b1, frame_tick = 1'b0, mouse_left = 1'b0;
    logic        first_player = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0, chk_hit = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic [3:0]  ship_count = '0;
    logic [1:0]  rx_kind = '0;
    logic [7:0]  rx_addr = '0;
    logic [7:0]  cursor_cell, tx_addr, chk_addr;
    logic        cursor_in_grid, pick_ship, pick_place, tx_valid, chk_req, game_over, win;
    logic [1:0]  tx_kind;
    logic [6:0]  state_led;
    int          errs = 0, checks = 0;

    game_turn_ctl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick), .mouse_left_i(mouse_left),
        .mouse_xpos_i(xpos), .mouse_ypos_i(ypos), .first_player_i(first_player),
        .ship_count_i(ship_count), .cursor_cell_o(cursor_cell), .cursor_in_grid_o(cursor_in_grid),
        .pick_ship_o(pick_ship), .pick_place_o(pick_place), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .tx_kind_o(tx_kind), .tx_addr_o(tx_addr), .rx_valid_i(rx_valid),
        .rx_kind_i(rx_kind), .rx_addr_i(rx_addr), .chk_req_o(chk_req), .chk_addr_o(chk_addr),
        .chk_hit_i(chk_hit), .game_over_o(game_over), .win_o(win), .state_led_o(state_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step();
        chk("rst_led", 32'(state_led), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_cursor", 32'(cursor_cell), 32'h0);
        chk("rst_game_over", 32'(game_over), 32'h0);
        rst_n = 1'b1;
        first_player = 1'b1;
        mouse_left = 1'b1;
        step();
        chk("setup_led", 32'(state_led), 32'h01);
        chk("setup_pick_ship", 32'(pick_ship), 32'h1);
        ship_count = 4'd11;
        step();
        chk("setup_hold_while_pressed", 32'(state_led), 32'h01);
        mouse_left = 1'b0;
        step();
        chk("aim_led", 32'(state_led), 32'h10);
        chk("aim_pick_place", 32'(pick_place), 32'h1);
        xpos = 12'd600;
        ypos = 12'd417;
        tick();
        chk("out_grid_flag", 32'(cursor_in_grid), 32'h0);
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        chk("out_grid_click_ignored", 32'(state_led), 32'h10);
        xpos = 12'd709;
        tick();
        chk("cursor_cell", 32'(cursor_cell), 32'h73);
        chk("in_grid_flag", 32'(cursor_in_grid), 32'h1);
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        chk("shot_led", 32'(state_led), 32'h20);
        chk("shot_kind", 32'(tx_kind), 32'h1);
        chk("shot_addr", 32'(tx_addr), 32'h73);
        for (int i = 0; i < 5; i++) begin
            chk("shot_held_valid", 32'(tx_valid), 32'h1);
            chk("shot_held_addr", 32'(tx_addr), 32'h73);
            step();
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("wait_result_led", 32'(state_led), 32'h40);
        chk("wait_result_tx_idle", 32'(tx_valid), 32'h0);
        for (int i = 0; i < 119; i++) tick();
        chk("no_timeout_at_119", 32'(state_led), 32'h40);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("resend_valid", 32'(tx_valid), 32'h1);
        chk("resend_addr", 32'(tx_addr), 32'h73);
        chk("resend_kind", 32'(tx_kind), 32'h1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 119; i++) tick();
        frame_tick = 1'b1;
        rx_valid = 1'b1;
        rx_kind = 2'b11;
        step();
        frame_tick = 1'b0;
        rx_valid = 1'b0;
        chk("result_beats_timeout_led", 32'(state_led), 32'h02);
        chk("result_beats_timeout_tx", 32'(tx_valid), 32'h0);
        rx_valid = 1'b1;
        rx_kind = 2'b01;
        rx_addr = 8'h45;
        chk_hit = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("check_req", 32'(chk_req), 32'h1);
        chk("check_addr", 32'(chk_addr), 32'h45);
        chk("check_led", 32'(state_led), 32'h04);
        tx_ready = 1'b1;
        step();
        chk("result_valid", 32'(tx_valid), 32'h1);
        chk("result_kind_hit", 32'(tx_kind), 32'h3);
        chk("result_addr", 32'(tx_addr), 32'h45);
        chk("check_req_one_cycle", 32'(chk_req), 32'h0);
        step();
        tx_ready = 1'b0;
        chk_hit = 1'b0;
        chk("one_cycle_xfer_to_aim", 32'(state_led), 32'h10);
        rx_valid = 1'b1;
        rx_kind = 2'b11;
        step();
        rx_valid = 1'b0;
        chk("rx_dropped_in_aim", 32'(state_led), 32'h10);
        for (int r = 0; r < 10; r++) begin
            mouse_left = 1'b1;
            rx_valid = (r == 0);
            rx_kind = 2'b11;
            step();
            mouse_left = 1'b0;
            rx_valid = 1'b0;
            chk("round_shot_led", 32'(state_led), 32'h20);
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
            rx_valid = 1'b1;
            rx_kind = 2'b11;
            step();
            rx_valid = 1'b0;
            if (r < 9) begin
                chk("round_wait_peer_led", 32'(state_led), 32'h02);
                chk("round_not_over", 32'(game_over), 32'h0);
                rx_valid = 1'b1;
                rx_kind = 2'b01;
                rx_addr = 8'(r);
                step();
                rx_valid = 1'b0;
                step();
                chk("round_result_miss", 32'(tx_kind), 32'h2);
                tx_ready = 1'b1;
                step();
                tx_ready = 1'b0;
            end else begin
                chk("win_game_over", 32'(game_over), 32'h1);
                chk("win_flag", 32'(win), 32'h1);
                chk("win_led", 32'(state_led), 32'h0);
            end
        end
        rx_valid = 1'b1;
        rx_kind = 2'b01;
        step();
        rx_valid = 1'b0;
        chk("game_over_absorbing", 32'(game_over), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rerst_game_over", 32'(game_over), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rerst_aim_led", 32'(state_led), 32'h10);
        tick();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        chk("rerst_shot_valid", 32'(tx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_rst_led", 32'(state_led), 32'h0);
        chk("async_rst_pick_place", 32'(pick_place), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
